// File: rtl/tl_a_burst_arbiter.sv
// ============================================================================
// Module  : tl_a_burst_arbiter
// Brief   : Round-robin TileLink A-channel arbiter with burst locking and
//           D-channel response routing by requester ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tl_a_burst_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ID_W   = 2,
    parameter int SRC_W  = 3,
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic [N_REQ-1:0]          in_a_valid,
    output logic [N_REQ-1:0]          in_a_ready,
    input  logic [3*N_REQ-1:0]        in_a_opcode,
    input  logic [4*N_REQ-1:0]        in_a_size,
    input  logic [SRC_W*N_REQ-1:0]    in_a_source,
    input  logic [ADDR_W*N_REQ-1:0]   in_a_address,
    input  logic [8*N_REQ-1:0]        in_a_mask,
    input  logic [DATA_W*N_REQ-1:0]   in_a_data,

    output logic                      out_a_valid,
    input  logic                      out_a_ready,
    output logic [2:0]                out_a_opcode,
    output logic [3:0]                out_a_size,
    output logic [ID_W+SRC_W-1:0]     out_a_source,
    output logic [ADDR_W-1:0]         out_a_address,
    output logic [7:0]                out_a_mask,
    output logic [DATA_W-1:0]         out_a_data,

    input  logic                      out_d_valid,
    output logic                      out_d_ready,
    input  logic [ID_W+SRC_W-1:0]     out_d_source,
    output logic [N_REQ-1:0]          in_d_valid,
    input  logic [N_REQ-1:0]          in_d_ready,

    output logic                      route_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_last;
    logic [2:0]        r_cnt;
    logic              r_route_err;

    logic [ID_W-1:0]   w_idle_grant;
    logic [ID_W-1:0]   w_grant;
    logic              w_sel_valid;
    logic              w_valid;
    logic              w_fire;
    logic [2:0]        w_op;
    logic [3:0]        w_size;
    logic [SRC_W-1:0]  w_src;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_mask;
    logic [DATA_W-1:0] w_data;
    logic              w_multi;
    logic [2:0]        w_cnt_load;
    logic [ID_W-1:0]   w_d_id;
    logic              w_d_hit;

    // Scan downward over offsets so the smallest offset from last winner+1 wins.
    always_comb begin
        w_idle_grant = r_last;
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last) + k) % N_REQ;
            if (in_a_valid[idx]) begin
                w_idle_grant = ID_W'(idx);
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) ? w_idle_grant : r_grant;

    always_comb begin
        w_sel_valid = 1'b0;
        w_op        = '0;
        w_size      = '0;
        w_src       = '0;
        w_addr      = '0;
        w_mask      = '0;
        w_data      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_valid = in_a_valid[i];
                w_op        = in_a_opcode[i*3 +: 3];
                w_size      = in_a_size[i*4 +: 4];
                w_src       = in_a_source[i*SRC_W +: SRC_W];
                w_addr      = in_a_address[i*ADDR_W +: ADDR_W];
                w_mask      = in_a_mask[i*8 +: 8];
                w_data      = in_a_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_valid = ~reset & w_sel_valid;
    assign w_fire  = w_valid & out_a_ready;

    always_comb begin
        in_a_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            in_a_ready[i] = ~reset & out_a_ready & in_a_valid[i] & (w_grant == ID_W'(i));
        end
    end

    assign out_a_valid   = w_valid;
    assign out_a_opcode  = w_op;
    assign out_a_size    = w_size;
    assign out_a_source  = {w_grant, w_src};
    assign out_a_address = w_addr;
    assign out_a_mask    = w_mask;
    assign out_a_data    = w_data;

    // Data-carrying opcodes (0..3) span 2^(size-3) beats, clamped at 8.
    assign w_multi = (w_op[2] == 1'b0) && (w_size > 4'd3);

    always_comb begin
        case (w_size)
            4'd4:    w_cnt_load = 3'd1;
            4'd5:    w_cnt_load = 3'd3;
            default: w_cnt_load = 3'd7;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_grant <= '0;
            r_last  <= ID_W'(N_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_fire) begin
                        if (w_multi) begin
                            r_state <= S_BURST;
                            r_grant <= w_grant;
                            r_cnt   <= w_cnt_load;
                        end else begin
                            r_state <= S_IDLE;
                            r_last  <= w_grant;
                        end
                    end else if (w_valid && (r_state == S_IDLE)) begin
                        r_state <= S_HOLD;
                        r_grant <= w_grant;
                    end
                end
                S_BURST: begin
                    if (w_fire) begin
                        if (r_cnt == 3'd1) begin
                            r_state <= S_IDLE;
                            r_last  <= r_grant;
                            r_cnt   <= 3'd0;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // D routing: unknown IDs are sunk so the downstream never stalls on them.
    assign w_d_id = out_d_source[ID_W+SRC_W-1:SRC_W];

    always_comb begin
        in_d_valid  = '0;
        out_d_ready = 1'b1;
        w_d_hit     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_d_id == ID_W'(i)) begin
                w_d_hit       = 1'b1;
                in_d_valid[i] = out_d_valid;
                out_d_ready   = in_d_ready[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_route_err <= 1'b0;
        end else if (out_d_valid && !w_d_hit) begin
            r_route_err <= 1'b1;
        end
    end

    assign route_err = r_route_err;

endmodule

`default_nettype wire

// File: doc/tl_a_burst_arbiter.md
TL_A_BURST_ARBITER -- requirements
Module: tl_a_burst_arbiter

Interface
REQ-001 SHALL take these parameters, one per line (name, default, meaning):
- N_REQ, 3, number of upstream TileLink requesters.
- ID_W, 2, requester-ID bits prepended to source; 2^ID_W >= N_REQ.
- SRC_W, 3, upstream source width.
- ADDR_W, 25, address width.
- DATA_W, 64, beat width; beat = 8 bytes.
REQ-002 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning), clock and reset first:
- clock, in, 1, sole clock; all state on rising edge.
- reset, in, 1, synchronous active-high reset.
- in_a_valid, in, N_REQ, per-requester A valid.
- in_a_ready, out, N_REQ, per-requester A ready.
- in_a_opcode, in, 3*N_REQ, packed A opcode.
- in_a_size, in, 4*N_REQ, packed log2 byte size.
- in_a_source, in, SRC_W*N_REQ, packed source.
- in_a_address, in, ADDR_W*N_REQ, packed address.
- in_a_mask, in, 8*N_REQ, packed byte mask.
- in_a_data, in, DATA_W*N_REQ, packed data.
- out_a_valid, out, 1, downstream A valid.
- out_a_ready, in, 1, downstream A ready.
- out_a_opcode / size / address / mask / data, out, 3 / 4 / ADDR_W / 8 / DATA_W, muxed fields.
- out_a_source, out, ID_W+SRC_W, {requester ID, upstream source}.
- out_d_valid, in, 1, downstream D valid.
- out_d_ready, out, 1, downstream D ready.
- out_d_source, in, ID_W+SRC_W, D source, used for routing.
- in_d_valid, out, N_REQ, per-requester D valid.
- in_d_ready, in, N_REQ, per-requester D ready.
- route_err, out, 1, sticky: D arrived with requester ID >= N_REQ.

Function
REQ-004 SHALL implement state machine IDLE / HOLD / BURST.
REQ-005 In IDLE, SHALL grant the first valid requester scanning (last_winner+1) mod N_REQ upward with wrap; no valid -> out_a_valid=0.
REQ-006 A fields and valid SHALL pass combinationally from granted requester; zero-cycle latency.
REQ-007 in_a_ready[i] SHALL equal out_a_ready AND (i == grant) AND in_a_valid[i]; all other bits 0.
REQ-008 IDLE with out_a_valid=1 and out_a_ready=0 SHALL go HOLD, latching grant; HOLD keeps that grant regardless of other valids until the beat fires.
REQ-009 Beats per message: opcode in {0,1,2,3} and size>3 -> 2^(size-3) beats (max 8 at size 6); otherwise 1.
REQ-010 First-beat fire of a multi-beat message SHALL go BURST, latch grant, load 3-bit counter with beats-1; each further fire decrements it.
REQ-011 Fire with counter==1 in BURST, or fire of a 1-beat message, SHALL complete the message: state IDLE, last_winner <= grant.
REQ-012 Size >6 with data opcode SHALL be clamped to 8 beats.
REQ-013 in_d_valid[k] SHALL be out_d_valid AND (out_d_source[ID_W+SRC_W-1:SRC_W]==k); out_d_ready SHALL be in_d_ready[k] of that k.
REQ-014 D ID >= N_REQ SHALL give out_d_ready=1 (beat dropped) and set route_err next cycle; it stays set until reset.
REQ-015 A-grant and D-routing SHALL be independent; simultaneous A and D fires both complete in the same cycle.

Reset
REQ-016 Reset SHALL force state IDLE, counter 0, latched grant 0, last_winner N_REQ-1 (so requester 0 has first priority), route_err 0.
REQ-017 Reset asserted mid-HOLD or mid-BURST SHALL abandon the message; first cycle after reset arbitrates afresh per REQ-005.
REQ-018 During reset, in_a_ready SHALL be all 0 and out_a_valid 0.

Verification
REQ-019 All three valid, 1-beat Gets (opcode 4, size 3), out_a_ready=1 -> grants 0,1,2,0 on successive cycles; out_a_source = {ID,src}.
REQ-020 Req1 PutFull size 6 (8 beats) while req0/2 valid -> eight consecutive req1 beats, no interleave; next grant req2.
REQ-021 Req0 valid, out_a_ready=0 for 3 cycles, req2 asserts meanwhile -> grant stays req0 (HOLD); req0 fires on cycle 4, then req2.
REQ-022 out_d_source = 5'b10_011, in_d_ready[2]=0 then 1 -> in_d_valid=3'b100, out_d_ready follows 0 then 1; route_err stays 0.
REQ-023 out_d_source = 5'b11_000 valid -> out_d_ready=1, route_err=1 next cycle and held; reset clears it.
REQ-024 Reset on beat 3 of req1 8-beat burst, all requesters valid afterward -> first post-reset grant is req0.
